c_register_file: RTL and testbench

Parametrised multi-entry register file, successor to the single `C_Register`. It provides one synchronous write port and two combinational read ports with same-cycle write bypass. A single shadow bank supports one-cycle snapshot, restore and swap, used for interrupt context save. It sits in the datapath between instruction decode (addresses) and the ALU operand muxes.

---
 rtl/unicycle_pkg.sv | 8 +
 rtl/c_register_entry.sv | 49 ++++
 rtl/c_register_file.sv | 98 +++++++++
 tb/tb_c_register_file.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/unicycle_pkg.sv
// Shared datapath constants and types for the unicycle core.
// Register-file defaults live here so decode and the ALU agree on widths.
package unicycle_pkg;
  localparam int DATA_BITS     = 16;
  localparam int REG_ADDR_BITS = 4;

  typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;
endpackage

// File: rtl/c_register_entry.sv
// One live/shadow register pair with write, snapshot, restore and swap loads.
// The top guarantees that at most one of snap/restore/swap is asserted.
module c_register_entry
  import unicycle_pkg::*;
#(
  parameter int BITS = DATA_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr,
  input  logic [BITS-1:0] wdata,
  input  logic            snap,
  input  logic            restore,
  input  logic            swap,
  output logic [BITS-1:0] live
);

  logic [BITS-1:0] live_reg;
  logic [BITS-1:0] shadow_reg;
  logic [BITS-1:0] live_next;
  logic [BITS-1:0] shadow_next;

  // A write always wins over a restored value so it lands in the live bank.
  always_comb begin
    live_next = (restore || swap) ? shadow_reg : live_reg;
    if (wr) begin
      live_next = wdata;
    end
    shadow_next = shadow_reg;
    if (swap) begin
      shadow_next = live_reg;
    end else if (snap) begin
      shadow_next = live_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_reg   <= '0;
      shadow_reg <= '0;
    end else begin
      live_reg   <= live_next;
      shadow_reg <= shadow_next;
    end
  end

  assign live = live_reg;

endmodule

// File: rtl/c_register_file.sv
// Multi-entry register file: one write port, two bypassed read ports and a
// single shadow bank for one-cycle interrupt context snapshot/restore/swap.
module c_register_file
  import unicycle_pkg::*;
#(
  parameter int BITS      = DATA_BITS,
  parameter int ADDR_BITS = REG_ADDR_BITS,
  parameter bit ZERO_REG  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [BITS-1:0]      wdata,
  input  logic [ADDR_BITS-1:0] raddr_a,
  output logic [BITS-1:0]      rdata_a,
  input  logic [ADDR_BITS-1:0] raddr_b,
  output logic [BITS-1:0]      rdata_b,
  input  logic                 snap,
  input  logic                 restore,
  output logic                 shadow_valid,
  output logic                 err
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic            shadow_valid_reg;
  logic            err_reg;
  logic            wr_ok;
  logic            do_restore;
  logic            snap_only;
  logic            restore_only;
  logic            swap;
  logic [BITS-1:0] live [DEPTH];

  assign wr_ok        = we && !(ZERO_REG && (waddr == '0));
  assign do_restore   = restore && shadow_valid_reg;
  assign snap_only    = snap && !do_restore;
  assign restore_only = do_restore && !snap;
  assign swap         = snap && do_restore;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (ZERO_REG && gi == 0) begin : g_zero
        assign live[gi] = '0;
      end else begin : g_reg
        c_register_entry #(
          .BITS (BITS)
        ) u_entry (
          .clk     (clk),
          .rst     (rst),
          .wr      (we && (waddr == ADDR_BITS'(gi))),
          .wdata   (wdata),
          .snap    (snap_only),
          .restore (restore_only),
          .swap    (swap),
          .live    (live[gi])
        );
      end
    end
  endgenerate

  // Bypass follows the pending write only; a pending restore is not forwarded.
  always_comb begin
    rdata_a = live[raddr_a];
    if (wr_ok && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
    if (ZERO_REG && (raddr_a == '0)) begin
      rdata_a = '0;
    end
    rdata_b = live[raddr_b];
    if (wr_ok && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
    if (ZERO_REG && (raddr_b == '0)) begin
      rdata_b = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_valid_reg <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      err_reg <= restore && !shadow_valid_reg;
      if (snap) begin
        shadow_valid_reg <= 1'b1;
      end else if (do_restore) begin
        shadow_valid_reg <= 1'b0;
      end
    end
  end

  assign shadow_valid = shadow_valid_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_c_register_file.sv
// Directed self-checking bench for c_register_file (default parameters).
module tb_c_register_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [3:0]  raddr_a;
  logic [15:0] rdata_a;
  logic [3:0]  raddr_b;
  logic [15:0] rdata_b;
  logic        snap;
  logic        restore;
  logic        shadow_valid;
  logic        err;

  int errors = 0;
  int checks = 0;

  c_register_file dut (
    .clk          (clk),
    .rst          (rst),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .raddr_a      (raddr_a),
    .rdata_a      (rdata_a),
    .raddr_b      (raddr_b),
    .rdata_b      (rdata_b),
    .snap         (snap),
    .restore      (restore),
    .shadow_valid (shadow_valid),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  // Advance past one rising edge; values are then sampled well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; snap = 1'b0; restore = 1'b0;
    #3;
    chk("rst_rdata", rdata_a, 16'h0000);
    chk("rst_sv", {15'b0, shadow_valid}, 16'h0001 & 16'h0000);
    chk("rst_err", {15'b0, err}, 16'h0000);
    @(negedge clk); rst = 1'b1;
    tick();

    // Write r3 while snapping, then reset mid-run
    raddr_a = 4'd3;
    snap = 1'b1;
    wr(4'd3, 16'h1234);
    snap = 1'b0;
    chk("r3_written", rdata_a, 16'h1234);
    chk("sv_after_snap", {15'b0, shadow_valid}, 16'h0001);
    #2 rst = 1'b0;
    #1;
    chk("midrst_r3", rdata_a, 16'h0000);
    chk("midrst_sv", {15'b0, shadow_valid}, 16'h0000);
    chk("midrst_err", {15'b0, err}, 16'h0000);
    @(negedge clk); rst = 1'b1;
    tick();
    chk("post_rst_r3", rdata_a, 16'h0000);

    // Write with same-cycle bypass
    we = 1'b1; waddr = 4'd5; wdata = 16'hFFF0; raddr_a = 4'd5; raddr_b = 4'd3;
    #1;
    chk("bypass_r5", rdata_a, 16'hFFF0);
    chk("bypass_other", rdata_b, 16'h0000);
    tick();
    we = 1'b0; wdata = 16'd32;
    #1;
    chk("r5_held", rdata_a, 16'hFFF0);

    // Zero register ignores writes and bypass
    we = 1'b1; waddr = 4'd0; wdata = 16'hAAAA; raddr_a = 4'd0; raddr_b = 4'd0;
    #1;
    chk("r0_byp_a", rdata_a, 16'h0000);
    chk("r0_byp_b", rdata_b, 16'h0000);
    tick();
    we = 1'b0;
    chk("r0_after_a", rdata_a, 16'h0000);
    chk("r0_after_b", rdata_b, 16'h0000);

    // Snapshot includes same-cycle write, restore brings it back
    wr(4'd1, 16'h0007);
    snap = 1'b1;
    wr(4'd2, 16'h0009);
    snap = 1'b0;
    chk("snap_sv", {15'b0, shadow_valid}, 16'h0001);
    wr(4'd1, 16'h0055);
    wr(4'd2, 16'h0066);
    raddr_a = 4'd1; raddr_b = 4'd2;
    restore = 1'b1;
    #1;
    chk("no_restore_byp", rdata_a, 16'h0055);
    tick();
    restore = 1'b0;
    chk("restored_r1", rdata_a, 16'h0007);
    chk("restored_r2", rdata_b, 16'h0009);
    chk("restore_sv", {15'b0, shadow_valid}, 16'h0000);
    chk("restore_err", {15'b0, err}, 16'h0000);
    raddr_a = 4'd5;
    #1;
    chk("restored_r5", rdata_a, 16'hFFF0);

    // Restore with a same-cycle write
    wr(4'd4, 16'h0010);
    snap = 1'b1; tick(); snap = 1'b0;
    wr(4'd5, 16'h1111);
    restore = 1'b1;
    wr(4'd4, 16'h0020);
    restore = 1'b0;
    raddr_a = 4'd4; raddr_b = 4'd5;
    #1;
    chk("rw_r4", rdata_a, 16'h0020);
    chk("rw_r5", rdata_b, 16'hFFF0);
    chk("rw_sv", {15'b0, shadow_valid}, 16'h0000);

    // Swap: live r6=1, shadow r6=2
    wr(4'd6, 16'h0002);
    snap = 1'b1; tick(); snap = 1'b0;
    wr(4'd6, 16'h0001);
    raddr_a = 4'd6;
    snap = 1'b1; restore = 1'b1;
    tick();
    snap = 1'b0; restore = 1'b0;
    chk("swap_live_r6", rdata_a, 16'h0002);
    chk("swap_sv", {15'b0, shadow_valid}, 16'h0001);
    chk("swap_err", {15'b0, err}, 16'h0000);
    restore = 1'b1; tick(); restore = 1'b0;
    chk("swap_shadow_r6", rdata_a, 16'h0001);
    chk("swap_rest_sv", {15'b0, shadow_valid}, 16'h0000);

    // Restore with no snapshot: error pulse, live unchanged, write still lands
    raddr_b = 4'd7;
    restore = 1'b1;
    wr(4'd7, 16'h0077);
    restore = 1'b0;
    chk("err_pulse", {15'b0, err}, 16'h0001);
    chk("err_r6_kept", rdata_a, 16'h0001);
    chk("err_r7_write", rdata_b, 16'h0077);
    tick();
    chk("err_one_cycle", {15'b0, err}, 16'h0000);

    // Snap+restore with no snapshot acts as snap and raises err
    snap = 1'b1; restore = 1'b1;
    tick();
    snap = 1'b0; restore = 1'b0;
    chk("sr_inv_err", {15'b0, err}, 16'h0001);
    chk("sr_inv_sv", {15'b0, shadow_valid}, 16'h0001);
    chk("sr_inv_r6", rdata_a, 16'h0001);
    tick();
    chk("sr_inv_err_end", {15'b0, err}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
